// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO with registered or first-word-fall-through read, fill count,
// almost-full/almost-empty thresholds, synchronous flush and overflow/underflow pulses.
module sync_fifo_ctl #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = FIFO_DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic                  Clr,
    input  logic [FIFO_WIDTH-1:0] Data_in,
    input  logic                  Wr_Req,
    input  logic                  Rd_Req,
    output logic [FIFO_WIDTH-1:0] Data_out,
    output logic                  Rd_Valid,
    output logic                  Full,
    output logic                  Empty,
    output logic                  Almost_Full,
    output logic                  Almost_Empty,
    output logic [PTR_W:0]        Count,
    output logic                  Overflow,
    output logic                  Underflow
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] AF_C    = (PTR_W + 1)'(AF_LEVEL);
    localparam logic [PTR_W:0] AE_C    = (PTR_W + 1)'(AE_LEVEL);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]        wptr;
    logic [PTR_W:0]        rptr;
    logic [PTR_W:0]        count_q;
    logic                  ovf_q;
    logic                  unf_q;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  rd_en;
    logic                  wr_en;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_ok = Rd_Req & ~Empty;
    assign wr_ok = Wr_Req & (~Full | rd_ok);
    assign rd_en = rd_ok & ~Clr;
    assign wr_en = wr_ok & ~Clr;

    assign Count        = count_q;
    assign Full         = (count_q == DEPTH_C);
    assign Empty        = (count_q == '0);
    assign Almost_Full  = (count_q >= AF_C);
    assign Almost_Empty = (count_q <= AE_C);
    assign Overflow     = ovf_q;
    assign Underflow    = unf_q;

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wptr[PTR_W-1:0]] <= Data_in;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else if (Clr) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_en) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + PTR_ONE;
                2'b01:   count_q <= count_q - PTR_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Error pulses report the request of the previous cycle; a flush masks them.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= Wr_Req & ~wr_ok & ~Clr;
            unf_q <= Rd_Req & ~rd_ok & ~Clr;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign Data_out = Empty ? '0 : mem[rptr[PTR_W-1:0]];
            assign Rd_Valid = ~Empty;
        end else begin : g_reg
            logic [FIFO_WIDTH-1:0] dout_q;
            logic                  valid_q;

            // Data_out keeps the last popped word until the next accepted read.
            always_ff @(posedge CLK or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else if (Clr) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_ok;
                    if (rd_ok) begin
                        dout_q <= mem[rptr[PTR_W-1:0]];
                    end
                end
            end

            assign Data_out = dout_q;
            assign Rd_Valid = valid_q;
        end
    endgenerate

endmodule
